// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing defaults, coordinate type and total helper
package vga_pkg;
  localparam int DEF_CW       = 10;
  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_WIN_X0   = 0;
  localparam int DEF_WIN_Y0   = 0;
  localparam int DEF_WIN_W    = 350;
  localparam int DEF_WIN_H    = 350;
  typedef logic [DEF_CW-1:0] coord_t;
  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis; flags are registered from the next count so they align with it
module vga_axis_counter import vga_pkg::*; #(
  parameter int CW     = DEF_CW,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          ce,
  input  logic          wrap_in,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          wrap_out,
  output logic          sync_flag,
  output logic          active_flag
);
  localparam int TOT = vga_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW:0] LAST    = (CW+1)'(TOT - 1);
  localparam logic [CW:0] SYNC_LO = (CW+1)'(ACTIVE + FP);
  localparam logic [CW:0] SYNC_HI = (CW+1)'(ACTIVE + FP + SYNC);
  localparam logic [CW:0] ACT     = (CW+1)'(ACTIVE);
  logic [CW:0] nxt_w;
  assign wrap_out  = {1'b0, count} == LAST;
  assign count_nxt = (ce && wrap_in) ? (wrap_out ? '0 : count + 1'b1) : count;
  assign nxt_w     = {1'b0, count_nxt};
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      count       <= '0;
      sync_flag   <= ~POL;
      active_flag <= 1'b0;
    end else if (ce) begin
      count       <= count_nxt;
      sync_flag   <= (nxt_w >= SYNC_LO && nxt_w < SYNC_HI) ? POL : ~POL;
      active_flag <= nxt_w < ACT;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: programmable VGA timing with pixel divider and window flag.
// VGA_TIMING_FRAME_CNT_EN adds a 16-bit frame counter output.
module vga_timing_gen import vga_pkg::*; #(
  parameter int CW       = DEF_CW,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int WIN_X0   = DEF_WIN_X0,
  parameter int WIN_Y0   = DEF_WIN_Y0,
  parameter int WIN_W    = DEF_WIN_W,
  parameter int WIN_H    = DEF_WIN_H
) (
  input  logic          Clk,
  input  logic          Reset,
  output logic          pix_ce,
  output logic          pixel_clk,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          line_start,
  output logic          frame_start,
  output logic          win_active,
  output logic [CW-1:0] WinX,
  output logic [CW-1:0] WinY
`ifdef VGA_TIMING_FRAME_CNT_EN
  , output logic [15:0] frame_cnt
`endif
);
  localparam int H_TOT = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW:0]   DIV_HALF = (DW+1)'(CLK_DIV / 2);
  localparam logic [CW:0] WX0 = (CW+1)'(WIN_X0);
  localparam logic [CW:0] WX1 = (CW+1)'(WIN_X0 + WIN_W);
  localparam logic [CW:0] WY0 = (CW+1)'(WIN_Y0);
  localparam logic [CW:0] WY1 = (CW+1)'(WIN_Y0 + WIN_H);
  localparam logic [CW:0] HA  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] VA  = (CW+1)'(V_ACTIVE);
  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end
  if (H_TOT > 2**CW || V_TOT > 2**CW) begin : g_bad_tot
    $error("timing totals exceed the counter range");
  end
  if (WIN_X0 + WIN_W > H_ACTIVE || WIN_Y0 + WIN_H > V_ACTIVE) begin : g_bad_win
    $error("window exceeds the active region");
  end
  logic [DW-1:0] div;
  logic          ce, h_wrap, v_wrap, h_act, v_act, in_win;
  logic [CW-1:0] hc_nxt, vc_nxt;
  logic [CW:0]   hn, vn;
  assign ce        = div == DIV_LAST;
  assign pixel_clk = CLK_DIV == 1 ? 1'b1 : {1'b0, div} < DIV_HALF;
  assign blank     = h_act & v_act;
  assign sync      = 1'b0;
  assign hn        = {1'b0, hc_nxt};
  assign vn        = {1'b0, vc_nxt};
  assign in_win    = hn >= WX0 && hn < WX1 && hn < HA && vn >= WY0 && vn < WY1 && vn < VA;
  vga_axis_counter #(
    .CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)
  ) u_h (
    .Clk(Clk), .Reset(Reset), .ce(ce), .wrap_in(1'b1),
    .count(DrawX), .count_nxt(hc_nxt), .wrap_out(h_wrap), .sync_flag(hs), .active_flag(h_act)
  );
  vga_axis_counter #(
    .CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)
  ) u_v (
    .Clk(Clk), .Reset(Reset), .ce(ce), .wrap_in(h_wrap),
    .count(DrawY), .count_nxt(vc_nxt), .wrap_out(v_wrap), .sync_flag(vs), .active_flag(v_act)
  );
  // strobes last one Clk: they are cleared on every non-load edge
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      div         <= '0;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      win_active  <= 1'b0;
      WinX        <= '0;
      WinY        <= '0;
    end else begin
      div         <= ce ? '0 : div + 1'b1;
      pix_ce      <= ce;
      line_start  <= ce && h_wrap;
      frame_start <= ce && h_wrap && v_wrap;
      if (ce) begin
        win_active <= in_win;
        WinX       <= in_win ? hc_nxt - WX0[CW-1:0] : '0;
        WinY       <= in_win ? vc_nxt - WY0[CW-1:0] : '0;
      end
    end
`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) frame_cnt <= '0;
    else if (ce && h_wrap && v_wrap) frame_cnt <= frame_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench on a tiny CLK_DIV=4 timing and the full 640x480 timing at CLK_DIV=1
module tb_vga_timing_gen;
  typedef struct packed {
    logic [9:0]  x, y;
    logic        hs, vs, bl, win;
    logic [9:0]  wx, wy;
    logic        ls, fs, pc, ce;
    logic [15:0] fc;
  } vec_t;
  typedef struct {
    int   g, x, y;
    logic hs, vs, bl, win;
    int   wx, wy;
  } dir_t;
  localparam int ND = 27;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  dir_t dirs[ND];
  int   hits[ND];
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D   = g == 0 ? 4 : 1;
    localparam int HA  = g == 0 ? 8 : 640;
    localparam int HF  = g == 0 ? 2 : 16;
    localparam int HSY = g == 0 ? 2 : 96;
    localparam int HB  = g == 0 ? 2 : 48;
    localparam int VA  = g == 0 ? 6 : 480;
    localparam int VF  = g == 0 ? 1 : 10;
    localparam int VSY = 2;
    localparam int VB  = g == 0 ? 1 : 33;
    localparam bit HP  = g == 0;
    localparam bit VP  = 1'b0;
    localparam int X0  = g == 0 ? 2 : 100;
    localparam int Y0  = g == 0 ? 1 : 50;
    localparam int WW  = g == 0 ? 3 : 16;
    localparam int WH  = g == 0 ? 2 : 8;
    localparam int HT  = HA + HF + HSY + HB;
    localparam int VT  = VA + VF + VSY + VB;
    logic        ce, pc, hs, vs, bl, sy, ls, fs, win;
    logic [9:0]  dx, dy, wx, wy;
    logic [15:0] fc;
    vec_t q[$];
    vec_t p, e, o, last;
    int   cnt, hx, vy, fcm;
    logic exp_pc;
    vga_timing_gen #(
      .CW(10), .CLK_DIV(D),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .HS_POL(HP), .VS_POL(VP),
      .WIN_X0(X0), .WIN_Y0(Y0), .WIN_W(WW), .WIN_H(WH)
    ) dut (
      .Clk(clk), .Reset(rst), .pix_ce(ce), .pixel_clk(pc), .hs(hs), .vs(vs),
      .blank(bl), .sync(sy), .DrawX(dx), .DrawY(dy), .line_start(ls),
      .frame_start(fs), .win_active(win), .WinX(wx), .WinY(wy)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc)
`endif
    );
`ifndef VGA_TIMING_FRAME_CNT_EN
    assign fc = '0;
`endif
    // predictor: one new pixel every D Clk after reset release
    always @(posedge clk) begin
      if (rst) begin
        cnt = 0; hx = 0; vy = 0; fcm = 0;
      end else begin
        cnt++;
        if (cnt % D == 0) begin
          hx = hx + 1 == HT ? 0 : hx + 1;
          if (hx == 0) vy = vy + 1 == VT ? 0 : vy + 1;
          if (hx == 0 && vy == 0) fcm++;
          p.x   = 10'(hx);
          p.y   = 10'(vy);
          p.hs  = (hx >= HA + HF && hx < HA + HF + HSY) ? HP : !HP;
          p.vs  = (vy >= VA + VF && vy < VA + VF + VSY) ? VP : !VP;
          p.bl  = hx < HA && vy < VA;
          p.win = p.bl && hx >= X0 && hx < X0 + WW && vy >= Y0 && vy < Y0 + WH;
          p.wx  = p.win ? 10'(hx - X0) : 10'd0;
          p.wy  = p.win ? 10'(vy - Y0) : 10'd0;
          p.ls  = hx == 0;
          p.fs  = hx == 0 && vy == 0;
          p.pc  = 1'b0;
          p.ce  = 1'b1;
`ifdef VGA_TIMING_FRAME_CNT_EN
          p.fc  = 16'(fcm);
`else
          p.fc  = '0;
`endif
          q.push_back(p);
        end
      end
    end
    // monitor: compares on every pix_ce, checks hold in between
    always @(negedge clk) begin
      o = {dx, dy, hs, vs, bl, win, wx, wy, ls, fs, pc, ce, fc};
      if (rst) begin
        q.delete();
        last = {20'd0, !HP, !VP, 2'b00, 20'd0, 2'b00, 1'b1, 1'b0, 16'd0};
        check($sformatf("dut%0d reset", g), o, last);
        check($sformatf("dut%0d sync", g), sy, 1'b0);
      end else begin
        exp_pc = D == 1 || (cnt % D) < D / 2;
        check($sformatf("dut%0d pix_ce", g), ce, q.size() != 0);
        if (ce && q.size() != 0) begin
          e = q.pop_front();
          e.pc = exp_pc;
          check($sformatf("dut%0d pixel (%0d,%0d)", g, e.x, e.y), o, e);
          last = e;
          last.ls = 1'b0;
          last.fs = 1'b0;
          last.ce = 1'b0;
          for (int i = 0; i < ND; i++)
            if (dirs[i].g == g && dirs[i].x == int'(dx) && dirs[i].y == int'(dy)) begin
              hits[i]++;
              check($sformatf("dut%0d directed (%0d,%0d)", g, dirs[i].x, dirs[i].y),
                    {hs, vs, bl, win, wx, wy},
                    {dirs[i].hs, dirs[i].vs, dirs[i].bl, dirs[i].win, 10'(dirs[i].wx), 10'(dirs[i].wy)});
            end
        end else if (!ce) begin
          q.delete();
          last.pc = exp_pc;
          check($sformatf("dut%0d hold", g), o, last);
        end
      end
    end
  end
  initial begin
    int n;
    dirs = '{
      '{1, 100, 50, 1, 1, 1, 1, 0, 0},
      '{1, 115, 57, 1, 1, 1, 1, 15, 7},
      '{1, 116, 57, 1, 1, 1, 0, 0, 0},
      '{1, 100, 58, 1, 1, 1, 0, 0, 0},
      '{1, 99, 50, 1, 1, 1, 0, 0, 0},
      '{1, 639, 3, 1, 1, 1, 0, 0, 0},
      '{1, 640, 3, 1, 1, 0, 0, 0, 0},
      '{1, 655, 3, 1, 1, 0, 0, 0, 0},
      '{1, 656, 3, 0, 1, 0, 0, 0, 0},
      '{1, 751, 3, 0, 1, 0, 0, 0, 0},
      '{1, 752, 3, 1, 1, 0, 0, 0, 0},
      '{1, 799, 3, 1, 1, 0, 0, 0, 0},
      '{0, 9, 0, 0, 1, 0, 0, 0, 0},
      '{0, 10, 0, 1, 1, 0, 0, 0, 0},
      '{0, 11, 0, 1, 1, 0, 0, 0, 0},
      '{0, 12, 0, 0, 1, 0, 0, 0, 0},
      '{0, 13, 9, 0, 1, 0, 0, 0, 0},
      '{0, 0, 7, 0, 0, 0, 0, 0, 0},
      '{0, 3, 8, 0, 0, 0, 0, 0, 0},
      '{0, 3, 9, 0, 1, 0, 0, 0, 0},
      '{0, 2, 1, 0, 1, 1, 1, 0, 0},
      '{0, 4, 2, 0, 1, 1, 1, 2, 1},
      '{0, 5, 2, 0, 1, 1, 0, 0, 0},
      '{0, 2, 3, 0, 1, 1, 0, 0, 0},
      '{0, 7, 5, 0, 1, 1, 0, 0, 0},
      '{0, 0, 0, 0, 1, 1, 0, 0, 0},
      '{0, 1, 6, 0, 1, 0, 0, 0, 0}
    };
    for (int i = 0; i < ND; i++) hits[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (1000) @(posedge clk);
    n = 0;
    while (u[1].dx != 10'd300 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait DrawX==300", u[1].dx, 10'd300);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (48000) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < ND; i++)
      check($sformatf("directed entry %0d reached", i), hits[i] > 0, 1'b1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
